seg7_message_player: RTL and testbench

Parametrised 7-segment message sequencer for TinyTapeout user designs. It has a loadable message buffer of character codes and plays it back one glyph at a time on a single 7-segment digit. Glyph rate comes from a programmable prescaler. Optional blank gaps separate glyphs, and playback runs once or loops. It is the successor to our fixed-string 7-segment scrollers: the message is runtime-written, and speed, segment polarity and looping are selectable.

---
 rtl/seg7_message_player.sv | 189 ++++++++++++++++++
 tb/tb_seg7_message_player.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_message_player.sv
// seg7_message_player: plays a runtime-loaded message of character codes on
// a single 7-segment digit, one glyph per prescaler period. Each glyph can be
// followed by an optional blank gap, and playback can run once or loop.
//
// Control handshake: wr_en, clr, start and stop are single-cycle level
// strobes sampled on every rising clk edge. There is no ready signal. A
// strobe that is not legal in the current state is silently dropped:
//   - wr_en and clr act only when busy is low.
//   - start acts only when busy is low and msg_len is non-zero.
//   - stop acts only while busy is high.
// When several strobes arrive together in IDLE/DONE, clr beats start and
// start beats wr_en.

module seg7_message_player #(
  parameter int PRESCALE_W   = 22,
  parameter int MSG_DEPTH    = 32,
  parameter bit GAP_EN       = 1'b1,
  parameter bit COMMON_ANODE = 1'b1,
  localparam int LEN_W       = $clog2(MSG_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_code,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [1:0]       speed,
  output logic [7:0]       seg_out,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [LEN_W-1:0] msg_len
);

  localparam int PTR_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam logic [7:0] SEG_INV = COMMON_ANODE ? 8'hFF : 8'h00;
  localparam logic [7:0] BLANK   = SEG_INV;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PRESCALE_W-1:0] prescaler;
  logic [PRESCALE_W-1:0] tick_mask;
  logic [4:0]            mem [MSG_DEPTH];

  logic tick;
  logic is_last;
  logic full;
  logic ctrl_ok;
  logic do_write;
  logic start_ok;

  // Maps a character code to its segment pattern, with DP always off and
  // the whole byte inverted for common-anode displays.
  function automatic logic [7:0] glyph_of(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'h00: g = 7'h3F;
      5'h01: g = 7'h06;
      5'h02: g = 7'h5B;
      5'h03: g = 7'h4F;
      5'h04: g = 7'h66;
      5'h05: g = 7'h6D;
      5'h06: g = 7'h7D;
      5'h07: g = 7'h07;
      5'h08: g = 7'h7F;
      5'h09: g = 7'h6F;
      5'h0A: g = 7'h77;
      5'h0B: g = 7'h7C;
      5'h0C: g = 7'h39;
      5'h0D: g = 7'h5E;
      5'h0E: g = 7'h79;
      5'h0F: g = 7'h71;
      5'h11: g = 7'h76;
      5'h12: g = 7'h38;
      5'h13: g = 7'h73;
      5'h14: g = 7'h3E;
      5'h15: g = 7'h54;
      5'h16: g = 7'h50;
      5'h17: g = 7'h40;
      default: g = 7'h00;
    endcase
    return {1'b0, g} ^ SEG_INV;
  endfunction

  // The tick fires once the low (PRESCALE_W - speed) prescaler bits are all
  // ones. speed is used live, so a faster setting takes effect mid-glyph.
  always_comb begin
    tick_mask = {PRESCALE_W{1'b1}} >> speed;
    tick      = ((prescaler & tick_mask) == tick_mask);
    is_last   = !((LEN_W'(rd_ptr) + LEN_W'(1)) < msg_len);
    full      = (msg_len == LEN_W'(MSG_DEPTH));
    ctrl_ok   = (state == ST_IDLE) || (state == ST_DONE);
    start_ok  = start && (msg_len != '0);
    do_write  = ctrl_ok && !clr && !start_ok && wr_en && !full;
  end

  // The message buffer has no reset. Only the first msg_len entries are
  // ever read.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[msg_len[PTR_W-1:0]] <= wr_code;
    end
  end

  // Playback state machine, together with the read pointer, the prescaler
  // and the message bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      prescaler <= '0;
      msg_len   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (clr) begin
            msg_len  <= '0;
            overflow <= 1'b0;
            state    <= ST_IDLE;
          end else if (start_ok) begin
            state     <= ST_SHOW;
            rd_ptr    <= '0;
            prescaler <= '0;
          end else if (wr_en) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              msg_len <= msg_len + LEN_W'(1);
            end
          end
        end
        ST_SHOW, ST_GAP: begin
          if (stop) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            prescaler <= '0;
          end else if (tick) begin
            if ((state == ST_SHOW) && GAP_EN) begin
              state     <= ST_GAP;
              prescaler <= '0;
            end else if (!is_last) begin
              rd_ptr    <= rd_ptr + PTR_W'(1);
              state     <= ST_SHOW;
              prescaler <= (state == ST_SHOW) ? prescaler + PRESCALE_W'(1) : '0;
            end else if (loop_en) begin
              rd_ptr    <= '0;
              state     <= ST_SHOW;
              prescaler <= (state == ST_SHOW) ? prescaler + PRESCALE_W'(1) : '0;
            end else begin
              state     <= ST_DONE;
              prescaler <= '0;
            end
          end else begin
            prescaler <= prescaler + PRESCALE_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The segment register follows state and rd_ptr one cycle later. It is
  // blank whenever no glyph is being shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_out <= BLANK;
    end else if (state == ST_SHOW) begin
      seg_out <= glyph_of(mem[rd_ptr]);
    end else begin
      seg_out <= BLANK;
    end
  end

  assign busy = (state == ST_SHOW) || (state == ST_GAP);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seg7_message_player.sv
// Bench for seg7_message_player (PRESCALE_W=4, MSG_DEPTH=4, GAP_EN=1,
// COMMON_ANODE=1). Expected output timelines are built from the message
// model and the glyph-period arithmetic.

module tb_seg7_message_player;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_code;
  logic       clr;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [1:0] speed;
  logic [7:0] seg_out;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [2:0] msg_len;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [4:0] model_msg[$];
  logic       model_ovf;
  logic [7:0] exp_q[$];

  // Active-high glyph table for codes 0x00..0x1F.
  logic [7:0] glyph_tab [32] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71,
    8'h00, 8'h76, 8'h38, 8'h73, 8'h3E, 8'h54, 8'h50, 8'h40,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  seg7_message_player #(
    .PRESCALE_W  (4),
    .MSG_DEPTH   (4),
    .GAP_EN      (1'b1),
    .COMMON_ANODE(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_code (wr_code),
    .clr     (clr),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .speed   (speed),
    .seg_out (seg_out),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .msg_len (msg_len)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Common-anode pattern for a character code.
  function automatic logic [7:0] exp_glyph(input logic [4:0] code);
    logic [7:0] g;
    g = glyph_tab[code];
    return ~g;
  endfunction

  // Glyph period in cycles for a given speed (base period is 16 cycles).
  function automatic int period_of(input logic [1:0] s);
    return 16 >> s;
  endfunction

  // Appends one character. The caller is at a negedge; the task returns at
  // the negedge after the write edge.
  task automatic write_code(input logic [4:0] c);
    wr_en   = 1'b1;
    wr_code = c;
    @(negedge clk);
    wr_en = 1'b0;
    if (model_msg.size() < 4) model_msg.push_back(c);
    else model_ovf = 1'b1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_msg.delete();
    model_ovf = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected seg_out for sample k after the start edge. Sample 0 still
  // reflects the pre-start state. After that the timeline is a run of
  // 2*len segments of p cycles each, alternating glyph and gap.
  task automatic build_exp(input int p, input bit lp, input int n);
    int len;
    int j;
    exp_q.delete();
    len = model_msg.size();
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        exp_q.push_back(8'hFF);
      end else begin
        j = (k - 1) / p;
        if ((!lp && j >= 2 * len) || (j % 2 == 1)) exp_q.push_back(8'hFF);
        else exp_q.push_back(exp_glyph(model_msg[(j / 2) % len]));
      end
    end
  endtask

  // Pulses start and checks n samples. If wr_at >= 0, wr_en is asserted
  // for one cycle at that sample.
  task automatic run_and_check(input int p, input bit lp, input int n,
                               input int wr_at, input string name);
    logic [7:0] e;
    logic       eb;
    int         len;
    len = model_msg.size();
    build_exp(p, lp, n);
    pulse_start();
    for (int k = 0; k < n; k++) begin
      e  = exp_q.pop_front();
      eb = lp || (k < 2 * len * p);
      checks++;
      if (seg_out !== e) begin
        errors++;
        $display("FAIL %s seg k=%0d: got %h expected %h", name, k, seg_out, e);
      end
      checks++;
      if (busy !== eb || done !== !eb) begin
        errors++;
        $display("FAIL %s busy/done k=%0d: got %b/%b expected %b/%b",
                 name, k, busy, done, eb, !eb);
      end
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_code = 5'h05;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_out !== 8'hFF || busy !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || msg_len !== 3'd0) begin
      errors++;
      $display("FAIL reset: got seg=%h busy=%b done=%b ovf=%b len=%0d expected ff/0/0/0/0",
               seg_out, busy, done, overflow, msg_len);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_overflow();
    write_code(5'h11);
    write_code(5'h0E);
    write_code(5'h12);
    write_code(5'h12);
    checks++;
    if (msg_len !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: got len=%0d ovf=%b expected 4/0", msg_len, overflow);
    end
    write_code(5'h00);
    checks++;
    if (msg_len !== 3'(model_msg.size()) || overflow !== model_ovf) begin
      errors++;
      $display("FAIL overflow: got len=%0d ovf=%b expected %0d/%b",
               msg_len, overflow, model_msg.size(), model_ovf);
    end
    do_clr();
    checks++;
    if (msg_len !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr: got len=%0d ovf=%b expected 0/0", msg_len, overflow);
    end
    write_code(5'h11);
    write_code(5'h0E);
    write_code(5'h12);
    write_code(5'h12);
  endtask

  task automatic test_play_once();
    loop_en = 1'b0;
    speed   = 2'd0;
    run_and_check(16, 1'b0, 132, -1, "play_once");
    run_and_check(16, 1'b0, 132, -1, "replay");
  endtask

  task automatic test_loop_stop();
    loop_en = 1'b1;
    speed   = 2'd3;
    run_and_check(period_of(speed), 1'b1, 23, 5, "loop");
    // The state is now mid-GAP; stop takes effect at the next edge.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || seg_out !== 8'hFF) begin
        errors++;
        $display("FAIL stop i=%0d: got busy=%b done=%b seg=%h expected 0/0/ff",
                 i, busy, done, seg_out);
      end
      @(negedge clk);
    end
    checks++;
    if (msg_len !== 3'd4) begin
      errors++;
      $display("FAIL wr_busy: got len=%0d expected 4", msg_len);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_empty_and_blank();
    do_clr();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || seg_out !== 8'hFF || msg_len !== 3'd0) begin
        errors++;
        $display("FAIL empty_start i=%0d: got busy=%b done=%b seg=%h len=%0d expected 0/0/ff/0",
                 i, busy, done, seg_out, msg_len);
      end
      @(negedge clk);
    end
    write_code(5'h1B);
    speed = 2'd3;
    run_and_check(period_of(speed), 1'b0, 6, -1, "blank_code");
  endtask

  task automatic test_random_play();
    int len;
    int p;
    for (int r = 0; r < 4; r++) begin
      do_clr();
      checks++;
      if (done !== 1'b0 || msg_len !== 3'd0) begin
        errors++;
        $display("FAIL clr_done r=%0d: got done=%b len=%0d expected 0/0", r, done, msg_len);
      end
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) write_code(5'($urandom_range(0, 31)));
      speed = 2'($urandom_range(0, 3));
      p = period_of(speed);
      run_and_check(p, 1'b0, 2 * len * p + 3, -1, "random");
    end
  endtask

  task automatic test_async_reset();
    speed = 2'd0;
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset busy: got %b expected 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (seg_out !== 8'hFF || busy !== 1'b0 || done !== 1'b0 ||
        msg_len !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got seg=%h busy=%b done=%b len=%0d ovf=%b expected ff/0/0/0/0",
               seg_out, busy, done, msg_len, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    model_msg.delete();
    model_ovf = 1'b0;
    @(negedge clk);
  endtask

  // Main sequence.
  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_code   = '0;
    clr       = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    speed     = 2'd0;
    model_ovf = 1'b0;
    test_reset();
    test_write_overflow();
    test_play_once();
    test_loop_stop();
    test_empty_and_blank();
    test_random_play();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
